// File: rtl/comp_pkg.sv
// Shared definitions for the comp pipeline: FSM encodings, width helpers and
// the accumulator state type used by comp_accum.
package comp_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ACCUM = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM
    } accum_state_e;

    // Ceiling log2 with a floor of one bit so that degenerate counters stay legal.
    function automatic int clog2_w(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int acc_width_default(input int size);
        return 2 * size + 8;
    endfunction

endpackage

// File: rtl/comp_accum_if.sv
// Stream interface between comp, comp_accum and the downstream frame consumer.
interface comp_accum_if
    import comp_pkg::*;
#(
    parameter int p_size      = 1,
    parameter int p_acc_width = acc_width_default(p_size),
    parameter int p_frame_len = 4
) ();

    localparam int CW = clog2_w(p_frame_len + 1);

    logic [2*p_size-1:0]    i_param;
    logic [2*p_size-1:0]    i_param_2;
    logic                   i_dv;
    logic                   i_clear;
    logic                   i_ready;
    logic [p_acc_width-1:0] o_sum;
    logic                   o_valid;
    logic [CW-1:0]          o_count;
    logic                   o_overflow;

    modport slave (
        input  i_param, i_param_2, i_dv, i_clear, i_ready,
        output o_sum, o_valid, o_count, o_overflow
    );

    modport master (
        output i_param, i_param_2, i_dv, i_clear, i_ready,
        input  o_sum, o_valid, o_count, o_overflow
    );

endinterface

// File: rtl/comp_accum_fifo.sv
// Small frame-total FIFO with a registered first-word-fall-through head;
// pointers carry an extra wrap bit to separate full from empty.
module comp_accum_fifo
    import comp_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [width-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [width-1:0] head_o
);

    localparam int AW = clog2_w(depth);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [width-1:0] head_q, head_d;
    logic [width-1:0] mem_q [depth];
    logic             push_s;
    logic             pop_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_s   = pop_i && !empty_o;
    assign push_s  = push_i && (!full_o || pop_s);
    assign head_o  = head_q;

    // Next pointers and next head; a push landing at the new read slot bypasses memory.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            head_d   = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(push_s);
            rd_ptr_d = rd_ptr_q + (AW+1)'(pop_s);
            if (wr_ptr_d == rd_ptr_d) begin
                head_d = head_q;
            end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
                head_d = data_i;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Pointer and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s && !clear_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/comp_accum.sv
// Frame accumulator behind comp: sums both result words per strobe and queues
// frame totals. Optional COMP_ACCUM_SAT_EN saturates instead of wrapping.
module comp_accum
    import comp_pkg::*;
#(
    parameter int p_size       = 1,
    parameter int p_acc_width  = acc_width_default(p_size),
    parameter int p_frame_len  = 4,
    parameter int p_fifo_depth = 4
) (
    input  logic         clk,
    input  logic         rst,
    comp_accum_if.slave  bus
);

    localparam int              CW       = clog2_w(p_frame_len + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(p_frame_len - 1);

    accum_state_e           state_q, state_d;
    logic [p_acc_width-1:0] acc_q, acc_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [p_acc_width-1:0] term_s;
    logic [p_acc_width-1:0] acc_step_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [p_acc_width-1:0] head_s;

`ifdef COMP_ACCUM_SAT_EN
    function automatic logic [p_acc_width-1:0] acc_add(input logic [p_acc_width-1:0] a,
                                                       input logic [p_acc_width-1:0] b);
        logic [p_acc_width:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[p_acc_width] ? {p_acc_width{1'b1}} : s[p_acc_width-1:0];
    endfunction
`else
    function automatic logic [p_acc_width-1:0] acc_add(input logic [p_acc_width-1:0] a,
                                                       input logic [p_acc_width-1:0] b);
        return a + b;
    endfunction
`endif

    assign term_s     = p_acc_width'(bus.i_param) + p_acc_width'(bus.i_param_2);
    assign acc_step_s = acc_add(acc_q, term_s);
    assign pop_s      = !fifo_empty_s && bus.i_ready && !bus.i_clear;

    // Frame FSM: accumulate strobes, emit the total on the last one, track drops.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        push_s     = 1'b0;
        overflow_d = overflow_q;
        if (bus.i_clear) begin
            state_d    = S_IDLE;
            acc_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.i_dv) begin
                        state_d = S_IDLE;
                    end else if (p_frame_len == 1) begin
                        push_s = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                        acc_d   = acc_step_s;
                        count_d = CW'(1);
                    end
                end
                S_ACCUM: begin
                    if (!bus.i_dv) begin
                        state_d = S_ACCUM;
                    end else if (count_q == LAST_CNT) begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                        acc_d   = '0;
                        count_d = '0;
                    end else begin
                        acc_d   = acc_step_s;
                        count_d = count_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    count_d = '0;
                end
            endcase
            // A full FIFO can only take the frame if the head leaves this cycle.
            if (push_s && fifo_full_s && !pop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // FSM, accumulator, sample counter and sticky overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    comp_accum_fifo #(
        .width (p_acc_width),
        .depth (p_fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .clear_i (bus.i_clear),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (acc_step_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .head_o  (head_s)
    );

    assign bus.o_sum      = head_s;
    assign bus.o_valid    = !fifo_empty_s;
    assign bus.o_count    = count_q;
    assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_comp_accum.sv
// Scoreboard bench for comp_accum: a frame-level reference model queues expected
// totals, and a negedge monitor pops and compares whenever the DUT hands one off.
module tb_comp_accum;

    localparam int P_SIZE = 4;
    localparam int ACC_W  = 10;
    localparam int FL     = 4;
    localparam int DEPTH  = 4;
    localparam int MAXV   = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    comp_accum_if #(.p_size(P_SIZE), .p_acc_width(ACC_W), .p_frame_len(FL)) bus ();

    comp_accum #(
        .p_size       (P_SIZE),
        .p_acc_width  (ACC_W),
        .p_frame_len  (FL),
        .p_fifo_depth (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int frame[$];
    bit m_ovf = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames are lists of terms; totals follow the overflow rule.
    always @(posedge clk or negedge rst) begin
        int total;
        if (!rst) begin
            sb.delete();
            frame.delete();
            m_ovf = 1'b0;
        end else if (bus.i_clear) begin
            sb.delete();
            frame.delete();
            m_ovf = 1'b0;
        end else if (bus.i_dv) begin
            frame.push_back(int'(bus.i_param) + int'(bus.i_param_2));
            if (frame.size() == FL) begin
                total = frame.sum();
`ifdef COMP_ACCUM_SAT_EN
                total = (total > MAXV) ? MAXV : total;
`else
                total = total % (MAXV + 1);
`endif
                if (sb.size() == DEPTH) m_ovf = 1'b1;
                else sb.push_back(total);
                frame.delete();
            end
        end
    end

    // Monitor: checks state each cycle and consumes expected totals on handshakes.
    always @(negedge clk) begin
        int exp_sum;
        if (rst) begin
            check("valid", int'(bus.o_valid), int'(sb.size() != 0));
            check("count", int'(bus.o_count), frame.size());
            check("overflow", int'(bus.o_overflow), int'(m_ovf));
            if (bus.o_valid && bus.i_ready && !bus.i_clear) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got sum %0d, expected no output", bus.o_sum);
                end else begin
                    exp_sum = sb.pop_front();
                    check("sum", int'(bus.o_sum), exp_sum);
                end
            end
        end
    end

    task automatic step(input bit dv, input int a, input int b, input bit rdy, input bit clr);
        bus.i_dv      = dv;
        bus.i_param   = 8'(a);
        bus.i_param_2 = 8'(b);
        bus.i_ready   = rdy;
        bus.i_clear   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int npops;
        bus.i_dv = 1'b0; bus.i_param = 8'd0; bus.i_param_2 = 8'd0;
        bus.i_ready = 1'b0; bus.i_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_sum", int'(bus.o_sum), 0);
        check("rst_count", int'(bus.o_count), 0);
        check("rst_overflow", int'(bus.o_overflow), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back frame of 0x10+0x05.
        for (int i = 0; i < 4; i++) step(1'b1, 16, 5, 1'b1, 1'b0);
        check("frame_valid", int'(bus.o_valid), 1);
        check("frame_sum", int'(bus.o_sum), 84);
        repeat (2) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Same frame with idle gaps.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16, 5, 1'b1, 1'b0);
            if (i < 3) repeat (3) step(1'b0, 0, 0, 1'b1, 1'b0);
        end
        check("gap_valid", int'(bus.o_valid), 1);
        check("gap_sum", int'(bus.o_sum), 84);
        repeat (2) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Five frames into a stalled four-entry FIFO.
        for (int i = 0; i < 20; i++) step(1'b1, 1, 0, 1'b0, 1'b0);
        check("bp_overflow", int'(bus.o_overflow), 1);
        check("bp_valid", int'(bus.o_valid), 1);
        repeat (6) step(1'b0, 0, 0, 1'b1, 1'b0);
        check("bp_drained", int'(bus.o_valid), 0);
        check("bp_sticky", int'(bus.o_overflow), 1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        check("bp_cleared", int'(bus.o_overflow), 0);

        // Full FIFO where the last strobe coincides with a pop.
        for (int i = 0; i < 16; i++) step(1'b1, 1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1, 0, 1'b0, 1'b0);
        step(1'b1, 1, 0, 1'b1, 1'b0);
        check("full_pp_overflow", int'(bus.o_overflow), 0);
        npops = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.o_valid) npops++;
            step(1'b0, 0, 0, 1'b1, 1'b0);
        end
        check("full_pp_entries", npops, 4);

        // Clear in the middle of a frame.
        step(1'b1, 7, 9, 1'b1, 1'b0);
        step(1'b1, 7, 9, 1'b1, 1'b0);
        step(1'b1, 3, 3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1, 1, 1'b1, 1'b0);
        check("clear_valid", int'(bus.o_valid), 1);
        check("clear_sum", int'(bus.o_sum), 8);
        repeat (2) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Large terms exceed the 10-bit accumulator.
        for (int i = 0; i < 4; i++) step(1'b1, 255, 255, 1'b1, 1'b0);
`ifdef COMP_ACCUM_SAT_EN
        check("sat_sum", int'(bus.o_sum), 1023);
`else
        check("wrap_sum", int'(bus.o_sum), 1016);
`endif
        repeat (2) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Randomized traffic with stalls and occasional clears.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 59) == 0));
        end
        step(1'b0, 0, 0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Asynchronous reset with a frame waiting in the FIFO.
        for (int i = 0; i < 4; i++) step(1'b1, 2, 3, 1'b0, 1'b0);
        step(1'b1, 1, 1, 1'b0, 1'b0);
        check("prereset_valid", int'(bus.o_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", int'(bus.o_valid), 0);
        check("async_sum", int'(bus.o_sum), 0);
        check("async_count", int'(bus.o_count), 0);
        check("async_overflow", int'(bus.o_overflow), 0);
        bus.i_dv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) step(1'b0, 0, 0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
